mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Sequencer and arbiter for the MAR/MDR/RAM memory subsystem.
- Two requesters share the memory:
  - port 0: instruction fetch, read-only.
  - port 1: data load/store.
- Grants one access at a time, round-robin. Drives the bus and the MARin, MDRin, read and write strobes in the order the subsystem needs. Captures read data from the MDR output and returns it with a one-cycle ack.

Parameters:
ADDR_W, 9, memory word-address width (zero-extended onto the bus).
DATA_W, 32, bus and data width.
RD_WAIT, 1, cycles read is held before MDR capture (RAM latency); values below 1 are treated as 1.

Ports:
clk  in  1  system clock; all state changes on rising edge.
clr  in  1  asynchronous active-low reset.
f_req  in  1  fetch request; held until f_ack.
f_addr  in  ADDR_W  fetch word address.
d_req  in  1  data request; held until d_ack.
d_we  in  1  1 = store, 0 = load.
d_addr  in  ADDR_W  data word address.
d_wdata  in  DATA_W  store data.
mdr_q  in  DATA_W  MDR register output from memory subsystem.
bus_out  out  DATA_W  value driven onto bus when bus_drive=1.
bus_drive  out  1  bus tristate/mux enable.
MARin  out  1  MAR load strobe.
MDRin  out  1  MDR load strobe.
read  out  1  RAM read / MDR source select (memory).
write  out  1  RAM write strobe.
rdata  out  DATA_W  captured read data; valid while f_ack or d_ack is high.
f_ack  out  1  one-cycle completion pulse to fetch port.
d_ack  out  1  one-cycle completion pulse to data port.
busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (clr=0, async): state=IDLE. All outputs 0; rdata=0. Round-robin pointer last=1, so port 0 wins the first tie. Latched request fields cleared.
- Moore outputs, decoded from the registered state only.
- IDLE
  - No req: stay.
  - Otherwise grant by round-robin:
    - Only one req: that port.
    - Both: port != last.
  - On the grant edge: latch port, addr, we (port 0 forces we=0) and wdata; set last=granted port; go ADDR.
- ADDR: bus_drive=1, bus_out=zero-extended latched addr, MARin=1. Next state RD if we=0, WDAT if we=1.
- RD: read=1 for RD_WAIT cycles (internal counter). MDRin=1 only on the final RD cycle. Then go RCAP.
- RCAP: all strobes 0; rdata <= mdr_q on exit edge. Go ACK.
- WDAT: bus_drive=1, bus_out=latched wdata, MDRin=1, read=0 (MDR loads from bus). Go WR.
- WR: write=1 for exactly one cycle; read=0. Go ACK.
- ACK: f_ack or d_ack=1 (granted port only) for one cycle. rdata holds the read value; unchanged on stores. Go IDLE.
- Latency from the IDLE cycle that samples req to the ack cycle:
  - Load: 3+RD_WAIT cycles.
  - Store: 4 cycles.
  - With default RD_WAIT=1, both are 4.
- Requester handshake:
  - Must deassert req the cycle after ack. If still high in IDLE, it is treated as a new request and arbitrated normally (last already updated).
  - Request inputs change mid-transaction: ignored, because fields were latched at grant.
- Strobe invariants:
  - read and write are never high together.
  - MARin and MDRin are never high together.
  - bus_drive is high only in ADDR/WDAT.
- Address bits are never truncated beyond ADDR_W; bus_out upper bits are 0 in ADDR.
- Reset mid-operation: strobes drop immediately; no ack is issued for the aborted access; the requester must re-request.
- busy=1 in ADDR, RD, RCAP, WDAT, WR, ACK.

Test Plan:
- Reset:
  - Stimulus: clr=0 with f_req=d_req=1.
  - Required: all outputs 0, state IDLE. After clr release, port 0 is granted first (MARin high the next cycle, bus_out=f_addr).
- Single store then load:
  - Stimulus: d_req, d_we=1, d_addr=9'h0A5, d_wdata=32'hDEADBEEF.
  - Required: MARin, MDRin, write on consecutive cycles; d_ack 4 cycles after grant.
  - Then load 0x0A5: rdata=32'hDEADBEEF with d_ack.
- Fetch read:
  - Stimulus: f_req, f_addr=9'h000, memory word 32'h12345678.
  - Required: read=1 for 1 cycle with MDRin; f_ack with rdata=32'h12345678; write never asserted.
- Contention:
  - Stimulus: f_req and d_req held high continuously for 4 transactions.
  - Required: grants alternate 0,1,0,1; each ack pulse is exactly 1 cycle; no overlap of read/write.
- Reset mid-store:
  - Stimulus: clr=0 during WDAT.
  - Required: write never asserted, no d_ack, busy=0 immediately; a subsequent retry completes normally.
- RD_WAIT=3 build:
  - Stimulus: a fetch read.
  - Required: read high 3 cycles, MDRin only on the third; f_ack 6 cycles after grant.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: round-robin arbiter and MAR/MDR/RAM access sequencer
// serving one read-only fetch port and one load/store data port.
module mem_access_ctrl #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 32,
    parameter int RD_WAIT = 1
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [DATA_W-1:0] mdr_q,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_drive,
    output logic              MARin,
    output logic              MDRin,
    output logic              read,
    output logic              write,
    output logic [DATA_W-1:0] rdata,
    output logic              f_ack,
    output logic              d_ack,
    output logic              busy
);

    localparam int RDW = (RD_WAIT < 1) ? 1 : RD_WAIT;
    localparam int CW  = (RDW > 1) ? $clog2(RDW) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(RDW - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_RD,
        S_RCAP,
        S_WDAT,
        S_WR,
        S_ACK
    } state_t;

    state_t            r_state;
    logic              r_port;
    logic              r_last;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic [CW-1:0]     r_cnt;
    logic              w_grant_d;
    logic              w_rd_last;

    // On a tie the port that was not served last wins.
    assign w_grant_d = d_req & (~f_req | ~r_last);
    assign w_rd_last = (r_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= S_IDLE;
            r_port  <= 1'b0;
            r_last  <= 1'b1;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_cnt   <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (f_req | d_req) begin
                        r_port  <= w_grant_d;
                        r_last  <= w_grant_d;
                        r_we    <= w_grant_d & d_we;
                        r_addr  <= w_grant_d ? d_addr : f_addr;
                        r_wdata <= w_grant_d ? d_wdata : '0;
                        r_state <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    r_cnt   <= '0;
                    r_state <= r_we ? S_WDAT : S_RD;
                end
                S_RD: begin
                    if (w_rd_last) begin
                        r_state <= S_RCAP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RCAP: begin
                    r_rdata <= mdr_q;
                    r_state <= S_ACK;
                end
                S_WDAT:  r_state <= S_WR;
                S_WR:    r_state <= S_ACK;
                S_ACK:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign MARin     = (r_state == S_ADDR);
    assign bus_drive = (r_state == S_ADDR) | (r_state == S_WDAT);
    assign bus_out   = (r_state == S_ADDR) ? DATA_W'(r_addr)
                     : (r_state == S_WDAT) ? r_wdata
                     : '0;
    assign read      = (r_state == S_RD);
    assign MDRin     = (r_state == S_WDAT) | ((r_state == S_RD) & w_rd_last);
    assign write     = (r_state == S_WR);
    assign f_ack     = (r_state == S_ACK) & ~r_port;
    assign d_ack     = (r_state == S_ACK) & r_port;
    assign busy      = (r_state != S_IDLE);
    assign rdata     = r_rdata;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed plus random checks of mem_access_ctrl against
// a MAR/MDR/RAM model and a transaction-level reference memory.
module tb_mem_access_ctrl;

    localparam int AW = 9;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          clr;
    logic          f_req;
    logic [AW-1:0] f_addr;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] mdr_q;
    logic [DW-1:0] bus_out;
    logic          bus_drive;
    logic          MARin;
    logic          MDRin;
    logic          read;
    logic          write;
    logic [DW-1:0] rdata;
    logic          f_ack;
    logic          d_ack;
    logic          busy;

    logic          f_req3;
    logic [AW-1:0] f_addr3;
    logic [DW-1:0] bus_out3;
    logic          bus_drive3;
    logic          MARin3;
    logic          MDRin3;
    logic          read3;
    logic          write3;
    logic [DW-1:0] rdata3;
    logic          f_ack3;
    logic          d_ack3;
    logic          busy3;
    logic [DW-1:0] mdr3;
    logic [AW-1:0] mar3;

    always #5 clk = ~clk;

    mem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_WAIT(1)) u_dut (
        .clk(clk), .clr(clr),
        .f_req(f_req), .f_addr(f_addr),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .mdr_q(mdr_q), .bus_out(bus_out), .bus_drive(bus_drive),
        .MARin(MARin), .MDRin(MDRin), .read(read), .write(write),
        .rdata(rdata), .f_ack(f_ack), .d_ack(d_ack), .busy(busy)
    );

    mem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_WAIT(3)) u_dut3 (
        .clk(clk), .clr(clr),
        .f_req(f_req3), .f_addr(f_addr3),
        .d_req(1'b0), .d_we(1'b0), .d_addr('0), .d_wdata('0),
        .mdr_q(mdr3), .bus_out(bus_out3), .bus_drive(bus_drive3),
        .MARin(MARin3), .MDRin(MDRin3), .read(read3), .write(write3),
        .rdata(rdata3), .f_ack(f_ack3), .d_ack(d_ack3), .busy(busy3)
    );

    // Memory subsystem: MAR, MDR (bus or RAM source) and RAM.
    logic [AW-1:0] mar;
    logic [DW-1:0] mdr;
    logic [DW-1:0] ram [512];
    logic          pl_we;
    logic [AW-1:0] pl_a;
    logic [DW-1:0] pl_d;

    always @(posedge clk) begin
        if (pl_we) ram[pl_a] <= pl_d;
        if (MARin) mar <= bus_out[AW-1:0];
        if (MDRin) mdr <= read ? ram[mar] : bus_out;
        if (write) ram[mar] <= mdr;
    end
    assign mdr_q = mdr;

    function automatic logic [DW-1:0] rom3(input logic [AW-1:0] a);
        return {a, 23'h0} ^ 32'h3C5A_96E1 ^ {23'h0, a};
    endfunction

    always @(posedge clk) begin
        if (MARin3) mar3 <= bus_out3[AW-1:0];
        if (MDRin3) mdr3 <= read3 ? rom3(mar3) : bus_out3;
    end

    // Reference model state
    logic [DW-1:0] ref_mem [512];
    logic          m_last;
    logic [DW-1:0] m_rdata;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        chk1("rd_wr_excl", read & write, 1'b0);
        chk1("mar_mdr_excl", MARin & MDRin, 1'b0);
        chk1("ack_excl", f_ack & d_ack, 1'b0);
        chk1("bus_drive", bus_drive, MARin | (MDRin & ~read));
        chk1("busy_strobe",
             (MARin | MDRin | read | write | f_ack | d_ack | bus_drive) & ~busy,
             1'b0);
    endtask

    // One transaction from the IDLE sampling cycle to the ack cycle.
    task automatic serve();
        bit            pd;
        bit            we;
        bit            got;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        logic [AW-1:0] sf;
        logic [AW-1:0] sd;
        logic [DW-1:0] sw;
        logic          swe;
        int            k_ack, k_mar, k_mdr, k_wr, n_mar, n_mdr, n_rd, n_wr;
        pd  = (f_req && d_req) ? ~m_last : d_req;
        we  = pd & d_we;
        a   = pd ? d_addr : f_addr;
        wd  = d_wdata;
        sf  = f_addr;
        sd  = d_addr;
        sw  = d_wdata;
        swe = d_we;
        got = 0;
        k_ack = 0; k_mar = 0; k_mdr = 0; k_wr = 0;
        n_mar = 0; n_mdr = 0; n_rd = 0; n_wr = 0;
        for (int k = 1; k <= 20 && !got; k++) begin
            tick();
            if (k == 1) begin
                f_addr  = AW'($urandom);
                d_addr  = AW'($urandom);
                d_wdata = $urandom;
                d_we    = 1'($urandom);
            end
            if (MARin) begin
                n_mar++;
                k_mar = k;
                chk("addr_on_bus", bus_out, DW'(a));
            end
            if (MDRin) begin
                n_mdr++;
                k_mdr = k;
                if (!read) chk("wdata_on_bus", bus_out, wd);
            end
            if (read) n_rd++;
            if (write) begin
                n_wr++;
                k_wr = k;
            end
            if (f_ack | d_ack) begin
                got     = 1;
                k_ack   = k;
                f_addr  = sf;
                d_addr  = sd;
                d_wdata = sw;
                d_we    = swe;
            end
        end
        chk1("ack_seen", got, 1'b1);
        chk1("ack_port_f", f_ack, ~pd);
        chk1("ack_port_d", d_ack, pd);
        chk("latency", k_ack, 4);
        chk("mar_cycle", k_mar, 1);
        chk("mar_count", n_mar, 1);
        chk("mdr_count", n_mdr, 1);
        chk("mdr_cycle", k_mdr, 2);
        chk("read_cycles", n_rd, we ? 0 : 1);
        chk("write_cycles", n_wr, we ? 1 : 0);
        if (we) begin
            chk("write_cycle", k_wr, 3);
            ref_mem[a] = wd;
        end else begin
            m_rdata = ref_mem[a];
        end
        chk("rdata", rdata, m_rdata);
        m_last = pd;
    endtask

    task automatic after_ack();
        tick();
        chk1("ack_pulse", f_ack | d_ack, 1'b0);
        chk1("idle_busy", busy, 1'b0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_bus_out"}, bus_out, '0);
        chk({tag, "_rdata"}, rdata, '0);
        chk1({tag, "_bus_drive"}, bus_drive, 1'b0);
        chk1({tag, "_MARin"}, MARin, 1'b0);
        chk1({tag, "_MDRin"}, MDRin, 1'b0);
        chk1({tag, "_read"}, read, 1'b0);
        chk1({tag, "_write"}, write, 1'b0);
        chk1({tag, "_f_ack"}, f_ack, 1'b0);
        chk1({tag, "_d_ack"}, d_ack, 1'b0);
        chk1({tag, "_busy"}, busy, 1'b0);
    endtask

    logic [AW-1:0] a0;
    logic [AW-1:0] a3;
    logic [DW-1:0] w0;
    int n_rd3, n_mdr3, k_mdr3, k_lrd, k_ack3, n_wr3;

    initial begin
        clr     = 1'b0;
        f_req   = 1'b0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        f_addr  = '0;
        d_addr  = '0;
        d_wdata = '0;
        f_req3  = 1'b0;
        f_addr3 = '0;
        pl_we   = 1'b0;
        pl_a    = '0;
        pl_d    = '0;
        m_last  = 1'b1;
        m_rdata = '0;

        for (int i = 0; i < 512; i++) begin
            pl_we = 1'b1;
            pl_a  = AW'(i);
            pl_d  = (i == 0) ? 32'h1234_5678 : $urandom;
            ref_mem[i] = pl_d;
            @(posedge clk);
            #1;
        end
        pl_we = 1'b0;

        // Reset with both requests pending
        f_req   = 1'b1;
        d_req   = 1'b1;
        f_addr  = 9'h1C3;
        d_addr  = 9'h07E;
        d_we    = 1'b1;
        d_wdata = 32'hA5A5_0F0F;
        tick();
        tick();
        chk_all_zero("reset");

        // Release; contention from reset must go 0,1,0,1
        clr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk1("rr_order", d_req && f_req && (m_last == 1'b1), i % 2 == 0);
            serve();
            after_ack();
            f_addr  = AW'($urandom);
            d_addr  = AW'($urandom);
            d_wdata = $urandom;
            d_we    = 1'($urandom);
        end
        f_req = 1'b0;
        d_req = 1'b0;
        tick();

        // Store then load of 0x0A5
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 9'h0A5;
        d_wdata = 32'hDEAD_BEEF;
        serve();
        d_req = 1'b0;
        after_ack();
        d_req = 1'b1;
        d_we  = 1'b0;
        serve();
        chk("load_0A5", rdata, 32'hDEAD_BEEF);
        d_req = 1'b0;
        after_ack();

        // Fetch of word 0
        f_req  = 1'b1;
        f_addr = 9'h000;
        serve();
        chk("fetch_000", rdata, 32'h1234_5678);
        f_req = 1'b0;
        after_ack();

        // Random mix of requests and fields
        for (int i = 0; i < 40; i++) begin
            f_req = 1'($urandom);
            d_req = 1'($urandom);
            if (!f_req && !d_req) d_req = 1'b1;
            f_addr  = AW'($urandom);
            d_addr  = AW'($urandom_range(15, 0));
            d_we    = 1'($urandom);
            d_wdata = $urandom;
            serve();
            after_ack();
        end
        f_req = 1'b0;
        d_req = 1'b0;
        tick();

        // Reset during WDAT of a store
        a0      = AW'($urandom_range(300, 200));
        w0      = ~ref_mem[a0];
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = a0;
        d_wdata = w0;
        tick();
        tick();
        chk1("in_wdat_MDRin", MDRin, 1'b1);
        chk1("in_wdat_read", read, 1'b0);
        #2;
        clr = 1'b0;
        #1;
        chk_all_zero("abort");
        d_req = 1'b0;
        m_last  = 1'b1;
        m_rdata = '0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk1("abort_write", write, 1'b0);
            chk1("abort_d_ack", d_ack, 1'b0);
        end
        clr   = 1'b1;
        d_req = 1'b1;
        d_we  = 1'b0;
        serve();
        d_req = 1'b0;
        after_ack();
        d_req = 1'b1;
        d_we  = 1'b1;
        serve();
        d_req = 1'b0;
        after_ack();
        d_req = 1'b1;
        d_we  = 1'b0;
        serve();
        chk("retry_load", rdata, w0);
        d_req = 1'b0;
        after_ack();

        // Slow-RAM build: fetch read with three read cycles
        f_req3  = 1'b1;
        f_addr3 = AW'($urandom);
        a3      = f_addr3;
        n_rd3 = 0; n_mdr3 = 0; k_mdr3 = 0; k_lrd = 0; k_ack3 = 0; n_wr3 = 0;
        for (int k = 1; k <= 20 && k_ack3 == 0; k++) begin
            @(posedge clk);
            #1;
            chk1("rw3_busy", busy3, 1'b1);
            chk1("rw3_rd_wr", read3 & write3, 1'b0);
            if (read3) begin
                n_rd3++;
                k_lrd = k;
            end
            if (MDRin3) begin
                n_mdr3++;
                k_mdr3 = k;
            end
            if (MARin3) chk("rw3_addr", bus_out3, DW'(a3));
            if (write3 | bus_drive3 & ~MARin3) n_wr3++;
            if (f_ack3) begin
                k_ack3 = k;
                f_req3 = 1'b0;
                chk1("rw3_d_ack", d_ack3, 1'b0);
                chk("rw3_rdata", rdata3, rom3(a3));
            end
        end
        chk("rw3_latency", k_ack3, 6);
        chk("rw3_read_cycles", n_rd3, 3);
        chk("rw3_mdr_count", n_mdr3, 1);
        chk("rw3_mdr_cycle", k_mdr3, 4);
        chk("rw3_mdr_on_last", k_mdr3, k_lrd);
        chk("rw3_no_write", n_wr3, 0);
        @(posedge clk);
        #1;
        chk1("rw3_idle", busy3, 1'b0);
        chk1("rw3_ack_pulse", f_ack3, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
